serial_shifter16_lr: RTL and testbench
======================================

# serial_shifter16_lr

Sequential 16-bit left/right shifter and rotator that executes one bit position per clock under a start/done handshake. It is the responding unit for the 16-bit shift/rotate stimulus drivers: the driver presents operand, shift count and direction, and this block returns the result after a count-dependent latency. It serves area-constrained datapaths where a combinational barrel shifter is too large.

## Interface
- No parameters; width fixed at 16 bits and count fixed at 4 bits.
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- x  input  16  operand; captured when start is accepted.
- shift  input  4  number of bit positions, 0..15; captured with x.
- leftOrRight  input  1  direction: 1 = left, 0 = right; captured with x.
- rotate  input  1  mode: 1 = rotate, 0 = logical shift with zero fill; captured with x.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse; result is valid while done is high.
- result  output  16  data register.

## Operation
- One clock, clk; reset_n is asynchronous and active-low.
- Reset, whenever reset_n = 0, including mid-operation, forces:
  - state = IDLE
  - result = 16'h0000
  - busy = 0, done = 0
  - internal count = 0
  - captured direction and mode = 0
- States are IDLE, RUN and DONE.
- IDLE:
  - If start = 1 at an edge: load the data register with x, count with shift, and capture leftOrRight and rotate. Go to RUN.
  - Otherwise hold. result keeps its last value.
- RUN:
  - If count = 0: go to DONE with no data change.
  - Otherwise, shift the data register by one position and decrement count.
- Single-bit operations:
  - Left logical: {d[14:0],1'b0}.
  - Right logical: {1'b0,d[15:1]}.
  - Left rotate: {d[14:0],d[15]}.
  - Right rotate: {d[0],d[15:1]}.
- DONE: done = 1 for exactly this one cycle, then go to IDLE.
- start is ignored while busy = 1. It is neither queued nor does it alter captured operands.
- Input changes after capture have no effect on the operation in flight.
- result shows intermediate values during RUN. It is stable and final from the DONE cycle until the next accepted start.
- Shift count 0 is legal: result = x, with the minimum latency.
- Count is never wider than 4 bits, so there is no wrap-around. Right shifts never sign-extend.

## Timing
- Take start as accepted at edge k, with N = shift.
- Shifts occur at edges k+1 .. k+N.
- The edge k+N+1 transition to DONE is the cycle that takes count = 0.
- done is high from edge k+N+1 to edge k+N+2.
- Latency from the accepting edge to done high is N+1 edges: 1 edge for N = 0, up to 16 edges for N = 15.
- busy rises after edge k and falls after edge k+N+2.
- The earliest next acceptance is edge k+N+3. With start held high continuously, back-to-back operations have a period of N+3 cycles.
- Asynchronous reset takes effect immediately, without waiting for clk. The first acceptance after release is at the first rising edge with reset_n = 1 and start = 1.

## Test plan
- Case 1: x = 16'hffff, shift = 4, leftOrRight = 0, rotate = 0 -> result = 16'h0fff; done is high exactly 5 edges after acceptance, and busy is high for 6 cycles.
- Case 2: x = 16'h00ff with rotate = 1.
  - Shift 4 left -> 16'h0ff0.
  - Shift 1 right -> 16'h807f.
  - Shift 15 left -> 16'h807f.
- Case 3: shift = 0, x = 16'h1234, either direction -> result = 16'h1234, done high 1 edge after acceptance.
- Case 4: sweep shift 1..15 with x = 16'hffff.
  - Right logical must give 16'hffff >> i.
  - Left logical must give 16'hffff << i, truncated to 16 bits; for example i = 15 -> 16'h8000.
  - done must be high i+1 edges after acceptance every time.
- Case 5: accept x = 16'h00ff, shift = 8, left logical. Then pulse start with x = 16'hffff, shift = 1 during RUN and during DONE.
  - Required: result = 16'hff00.
  - Required: exactly one done pulse.
  - Required: no second operation starts.
- Case 6: assert reset_n = 0 mid-RUN, between clock edges -> result = 0, busy = 0, done = 0 immediately. After release, a fresh start with x = 16'h0001, shift = 3, left logical -> 16'h0008.

Source files
------------

// File: rtl/serial_shifter16_lr_if.sv
// Request/response bundle between a 16-bit shift/rotate driver and the sequential shifter.
// Handshake: the driver raises start with x/shift/leftOrRight/rotate stable; the shifter accepts it
// on the first rising edge where it is idle (busy = 0), holds busy until the operation retires, and
// pulses done for one cycle while result carries the final value. start is not queued while busy.
interface serial_shifter16_lr_if;
  logic        start;
  logic [15:0] x;
  logic [3:0]  shift;
  logic        leftOrRight;
  logic        rotate;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [1:0]  state_dbg;

  modport master (
    output start, x, shift, leftOrRight, rotate,
    input  busy, done, result, state_dbg
  );

  modport slave (
    input  start, x, shift, leftOrRight, rotate,
    output busy, done, result, state_dbg
  );
endinterface

// File: rtl/serial_shifter16_lr.sv
// Sequential 16-bit shifter/rotator: one bit position per clock, IDLE -> RUN -> DONE.
// The data register doubles as the visible result, so intermediate values show during RUN.
module serial_shifter16_lr (
  input logic                  clk,
  input logic                  reset_n,
  serial_shifter16_lr_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_data;
  logic [3:0]  r_count;
  logic        r_left;
  logic        r_rot;
  logic [15:0] w_step;

  // Single-position step; the fill bit is either zero or the bit falling off the other end.
  always_comb begin
    w_step = r_data;
    case ({r_left, r_rot})
      2'b10:   w_step = {r_data[14:0], 1'b0};
      2'b00:   w_step = {1'b0, r_data[15:1]};
      2'b11:   w_step = {r_data[14:0], r_data[15]};
      2'b01:   w_step = {r_data[0], r_data[15:1]};
      default: w_step = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_count == 4'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are captured only on acceptance, so later input changes cannot disturb a run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= 16'h0000;
      r_count <= 4'd0;
      r_left  <= 1'b0;
      r_rot   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_data  <= bus.x;
            r_count <= bus.shift;
            r_left  <= bus.leftOrRight;
            r_rot   <= bus.rotate;
          end
        end
        S_RUN: begin
          if (r_count != 4'd0) begin
            r_data  <= w_step;
            r_count <= r_count - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_data;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_serial_shifter16_lr.sv
// Self-checking bench for serial_shifter16_lr: directed cases plus randomized operations
// compared against an arithmetic shift/rotate model.
module tb_serial_shifter16_lr;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  logic [15:0] exp_q[$];

  serial_shifter16_lr_if bus();

  serial_shifter16_lr dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic on a 32-bit value, no per-bit stepping.
  function automatic logic [15:0] ref_model(input logic [15:0] xi, input int n,
                                            input logic lr, input logic rot);
    int unsigned v;
    int unsigned r;
    v = xi;
    if (n == 0) return xi;
    if (lr) begin
      r = (v << n) & 32'hffff;
      if (rot) r = r | (v >> (16 - n));
    end else begin
      r = v >> n;
      if (rot) r = r | ((v << (16 - n)) & 32'hffff);
    end
    return r[15:0];
  endfunction

  // Driver: presents one request, then watches a fixed 20-edge window after acceptance.
  // With noise set, start is pulsed with a different operand during RUN and during DONE.
  task automatic do_op(input logic [15:0] xi, input logic [3:0] si, input logic lr,
                       input logic rot, input bit noise,
                       output logic [15:0] res, output logic [15:0] res_end,
                       output int lat, output int busy_cyc, output int done_cnt);
    @(negedge clk);
    bus.start = 1'b1; bus.x = xi; bus.shift = si; bus.leftOrRight = lr; bus.rotate = rot;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.x = 16'($urandom); bus.shift = 4'($urandom);
    bus.leftOrRight = 1'($urandom); bus.rotate = 1'($urandom);
    lat = -1; done_cnt = 0; res = 16'hxxxx;
    busy_cyc = bus.busy ? 1 : 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = e;
          res = bus.result;
        end
      end
      if (noise) begin
        bus.start = (e == 3) || bus.done;
        bus.x = 16'hffff; bus.shift = 4'd1;
      end
    end
    bus.start = 1'b0;
    res_end = bus.result;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.x = 16'h0; bus.shift = 4'd0; bus.leftOrRight = 1'b0; bus.rotate = 1'b0;
    #3;
    n_vec++;
    if (bus.result !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got result=%h busy=%b done=%b state=%0d, expected 0000/0/0/0",
               bus.result, bus.busy, bus.done, bus.state_dbg);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Common checks for one operation; exp_q holds the scoreboard expectation.
  task automatic run_and_check(input string name, input logic [15:0] xi, input logic [3:0] si,
                               input logic lr, input logic rot);
    logic [15:0] res, res_end, exp;
    int lat, bc, dc;
    exp_q.push_back(ref_model(xi, int'(si), lr, rot));
    do_op(xi, si, lr, rot, 1'b0, res, res_end, lat, bc, dc);
    exp = exp_q.pop_front();
    n_vec++;
    if (res !== exp || res_end !== exp) begin
      n_err++;
      $display("FAIL %s result: x=%h n=%0d lr=%b rot=%b got %h (later %h) expected %h",
               name, xi, si, lr, rot, res, res_end, exp);
    end
    n_vec++;
    if (lat != int'(si) + 1 || dc != 1) begin
      n_err++;
      $display("FAIL %s latency: n=%0d got %0d edges (%0d pulses) expected %0d edges (1 pulse)",
               name, si, lat, dc, int'(si) + 1);
    end
    n_vec++;
    if (bc != int'(si) + 2) begin
      n_err++;
      $display("FAIL %s busy_cycles: n=%0d got %0d expected %0d", name, si, bc, int'(si) + 2);
    end
  endtask

  task automatic test_case1();
    run_and_check("case1_right_logical", 16'hffff, 4'd4, 1'b0, 1'b0);
    n_vec++;
    if (ref_model(16'hffff, 4, 1'b0, 1'b0) !== 16'h0fff) begin
      n_err++;
      $display("FAIL case1_model: got %h expected 0fff", ref_model(16'hffff, 4, 1'b0, 1'b0));
    end
  endtask

  task automatic test_rotate();
    run_and_check("case2_rotl4",  16'h00ff, 4'd4,  1'b1, 1'b1);
    run_and_check("case2_rotr1",  16'h00ff, 4'd1,  1'b0, 1'b1);
    run_and_check("case2_rotl15", 16'h00ff, 4'd15, 1'b1, 1'b1);
  endtask

  task automatic test_zero_shift();
    run_and_check("case3_zero_left",  16'h1234, 4'd0, 1'b1, 1'b0);
    run_and_check("case3_zero_right", 16'h1234, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_sweep();
    for (int i = 1; i <= 15; i++) begin
      run_and_check("case4_sweep_right", 16'hffff, 4'(i), 1'b0, 1'b0);
      run_and_check("case4_sweep_left",  16'hffff, 4'(i), 1'b1, 1'b0);
    end
  endtask

  task automatic test_ignore_start();
    logic [15:0] res, res_end;
    int lat, bc, dc;
    do_op(16'h00ff, 4'd8, 1'b1, 1'b0, 1'b1, res, res_end, lat, bc, dc);
    n_vec++;
    if (res !== 16'hff00 || res_end !== 16'hff00) begin
      n_err++;
      $display("FAIL case5_result: got %h (later %h) expected ff00", res, res_end);
    end
    n_vec++;
    if (dc != 1 || lat != 9) begin
      n_err++;
      $display("FAIL case5_done: got %0d pulses at edge %0d expected 1 pulse at edge 9", dc, lat);
    end
    n_vec++;
    if (bc != 10) begin
      n_err++;
      $display("FAIL case5_no_second_op: busy cycles got %0d expected 10", bc);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.x = 16'h5a5a; bus.shift = 4'd10; bus.leftOrRight = 1'b1; bus.rotate = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.result !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL case6_async_reset: got result=%h busy=%b done=%b expected 0000/0/0",
               bus.result, bus.busy, bus.done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_and_check("case6_after_reset", 16'h0001, 4'd3, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_and_check("random", 16'($urandom), 4'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom));
    end
  endtask

  // start held high: done pulses should recur every N+3 edges.
  task automatic test_back_to_back();
    int t_done[$];
    int n;
    n = $urandom_range(0, 6);
    @(negedge clk);
    bus.start = 1'b1; bus.x = 16'h8001; bus.shift = 4'(n); bus.leftOrRight = 1'b0; bus.rotate = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (bus.done) t_done.push_back(e);
    end
    bus.start = 1'b0;
    n_vec++;
    if (t_done.size() < 3 || (t_done[1] - t_done[0]) != n + 3 || (t_done[2] - t_done[1]) != n + 3) begin
      n_err++;
      $display("FAIL back_to_back_period: n=%0d pulses=%0d gap=%0d expected gap %0d",
               n, t_done.size(), (t_done.size() >= 2) ? t_done[1] - t_done[0] : -1, n + 3);
    end
    repeat (n + 4) @(posedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_case1();
    test_rotate();
    test_zero_shift();
    test_sweep();
    test_ignore_start();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
